multi_decoder: RTL and testbench
================================

MULTI_DECODER -- requirements
Module: multi_decoder

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 5: per-channel address width.
REQ-002 SHALL have parameter CH, default 2: number of request channels, range 1..8.
REQ-003 SHALL have parameter ACTIVE, default 1: out_onehot polarity (1 = active-high, 0 = active-low).
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1: request present.
REQ-007 SHALL have port in_ready, output, 1: request accepted when in_valid && in_ready at the clk edge.
REQ-008 SHALL have port in_addr, input, CH*IN_WIDTH: channel k address in bits [k*IN_WIDTH +: IN_WIDTH].
REQ-009 SHALL have port in_mask, input, CH: channel k participates when bit k = 1.
REQ-010 SHALL have port out_valid, output, 1: output beat present.
REQ-011 SHALL have port out_ready, input, 1: beat consumed when out_valid && out_ready.
REQ-012 SHALL have port out_onehot, output, 1<<IN_WIDTH: bitwise OR of the decodes of the channels served this beat, polarity per ACTIVE.
REQ-013 SHALL have port out_ch, output, CH: channels served this beat (active-high regardless of ACTIVE).

Function
REQ-014 SHALL capture in_addr and in_mask into a pending register on acceptance; pending mask = in_mask.
REQ-015 SHALL drive in_ready = (pending mask == 0) && (!out_valid || out_ready), combinationally.
REQ-016 SHALL use FSM states IDLE (pending empty) and SERVE (pending non-empty); IDLE->SERVE on acceptance with non-zero in_mask; SERVE->IDLE when the last pending channel is loaded into the output register.
REQ-017 SHALL accept a request with in_mask == 0 and drop it: no beat, state stays IDLE.
REQ-018 SHALL, per beat, serve every pending channel whose address differs from that of all lower-index pending channels; lowest index wins each collision.
REQ-019 SHALL defer colliding channels to subsequent beats, one beat per collision level; CH channels with equal addresses need exactly CH beats.
REQ-020 SHALL load a beat into the output register when in SERVE and (!out_valid || out_ready); out_valid asserts on the next edge.
REQ-021 SHALL produce the first beat with out_valid high one cycle after acceptance (latency 1); with out_ready held high, successive beats issue on consecutive cycles.
REQ-022 SHALL hold out_onehot and out_ch stable while out_valid && !out_ready.
REQ-023 SHALL deassert out_valid after consumption when no pending channel remains.
REQ-024 SHALL allow the acceptance of a new request in the same cycle as the last beat is consumed (back-to-back, no bubble).

Reset
REQ-025 SHALL, while rst is high, force out_valid = 0, out_ch = 0, out_onehot = all bits ~ACTIVE, pending mask = 0, state = IDLE, and in_ready = 0.
REQ-026 SHALL discard pending channels and any unconsumed beat when rst asserts mid-operation; no beat emitted after release until a new acceptance.

Configuration
REQ-027 SHALL support macro MULTI_DECODER_ENABLE_PIN_EN: when defined, adds input enable (1 bit); enable = 0 blocks acceptance (in_ready = 0) and beat loading, and holds out_valid, out_onehot and out_ch; when undefined, the module behaves as enable = 1 and has no enable port.

Structure
REQ-028 SHALL place the FSM state enum and a helper function onehot_decode(addr, width) in package multi_decoder_pkg.
REQ-029 SHALL instantiate the existing decoder module, one instance per channel with ACTIVE = 1, and apply polarity only at out_onehot.

Verification
REQ-030 SHALL cover IN_WIDTH=5, CH=2: addresses {3,7}, mask 2'b11 -> one beat at t+1, out_onehot = 0x00000088, out_ch = 2'b11.
REQ-031 SHALL cover a collision: addresses {4,4}, mask 2'b11 -> beat 1 out_ch = 2'b01, out_onehot = 0x10; beat 2 out_ch = 2'b10, out_onehot = 0x10; in_ready high only after beat 2 is consumed.
REQ-032 SHALL cover backpressure: out_ready = 0 for 5 cycles -> out_valid and outputs stable, in_ready = 0; out_ready = 1 -> consumed, next request accepted the same cycle.
REQ-033 SHALL cover ACTIVE=0: address {0}, mask 2'b01 -> out_onehot = 0xFFFFFFFE; after reset, out_onehot = 0xFFFFFFFF.
REQ-034 SHALL cover an empty request: mask 2'b00 -> accepted, no out_valid; and rst pulsed during a 2-beat collision -> no second beat emitted.
REQ-035 SHALL cover a build with MULTI_DECODER_ENABLE_PIN_EN defined: enable = 0 during SERVE -> outputs frozen; enable = 1 -> remaining beat delivered.

Source files
------------

// File: rtl/multi_decoder_pkg.sv
// Shared types and helpers for the multi-channel address decoder.
// Optional feature macro: MULTI_DECODER_ENABLE_PIN_EN (adds an enable input).
package multi_decoder_pkg;

  // IDLE: nothing pending; SERVE: at least one channel still to be issued
  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  // Widest address the decode helper supports
  localparam int MAX_WIDTH = 8;

  // Active-high one-hot decode of addr, limited to a field of 2**width bits
  function automatic logic [(1<<MAX_WIDTH)-1:0] onehot_decode(
    input logic [MAX_WIDTH-1:0] addr,
    input int                   width
  );
    logic [(1<<MAX_WIDTH)-1:0] result;
    result = '0;
    if (int'(addr) < (1 << width)) begin
      result[addr] = 1'b1;
    end
    return result;
  endfunction

endpackage

// File: rtl/multi_decoder_dec.sv
// Single-channel address-to-one-hot decoder with selectable polarity.
// Optional feature macro of the enclosing block: MULTI_DECODER_ENABLE_PIN_EN (unused here).
module multi_decoder_dec
  import multi_decoder_pkg::*;
#(
  parameter int IN_WIDTH = 5,
  parameter int ACTIVE   = 1
) (
  input  logic [IN_WIDTH-1:0]      addr,
  output logic [(1<<IN_WIDTH)-1:0] onehot
);

  logic [(1<<MAX_WIDTH)-1:0] full_decode;

  // Decode through the shared helper, then keep only the bits this width uses
  always_comb begin
    full_decode = onehot_decode(MAX_WIDTH'(addr), IN_WIDTH);
  end

  assign onehot = (ACTIVE != 0) ? full_decode[(1<<IN_WIDTH)-1:0]
                                : ~full_decode[(1<<IN_WIDTH)-1:0];

  // Upper decode bits are always zero for narrower addresses
  if (IN_WIDTH < MAX_WIDTH) begin : g_sink
    logic unused_hi;
    assign unused_hi = |full_decode[(1<<MAX_WIDTH)-1:(1<<IN_WIDTH)];
  end

endmodule

// File: rtl/multi_decoder.sv
// Multi-channel address decoder: accepts CH addresses per request and issues
// one or more output beats, each the OR of the decodes of non-colliding channels.
// Colliding channels (same address as a lower-index pending channel) are
// deferred to later beats. Optional feature macro: MULTI_DECODER_ENABLE_PIN_EN
// adds an 'enable' input that freezes acceptance and beat progress when low.
module multi_decoder
  import multi_decoder_pkg::*;
#(
  parameter int IN_WIDTH = 5,
  parameter int CH       = 2,
  parameter int ACTIVE   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CH*IN_WIDTH-1:0]   in_addr,
  input  logic [CH-1:0]            in_mask,
  output logic                     out_valid,
  input  logic                     out_ready,
`ifdef MULTI_DECODER_ENABLE_PIN_EN
  input  logic                     enable,
`endif
  output logic [(1<<IN_WIDTH)-1:0] out_onehot,
  output logic [CH-1:0]            out_ch
);

  localparam int OH_W = 1 << IN_WIDTH;

  logic                   en;
  state_t                 state_reg;
  logic [CH*IN_WIDTH-1:0] pend_addr_reg;
  logic [CH-1:0]          pend_mask_reg;
  logic                   out_valid_reg;
  logic [OH_W-1:0]        out_onehot_reg;
  logic [CH-1:0]          out_ch_reg;

  logic [IN_WIDTH-1:0]    ch_addr   [CH];
  logic [OH_W-1:0]        dec_onehot[CH];
  logic [CH-1:0]          serve_next;
  logic [CH-1:0]          remain_next;
  logic [OH_W-1:0]        beat_next;
  logic                   accept;
  logic                   load;

`ifdef MULTI_DECODER_ENABLE_PIN_EN
  assign en = enable;
`else
  assign en = 1'b1;
`endif

  // One active-high decoder per channel; polarity is applied only at the port
  for (genvar gi = 0; gi < CH; gi++) begin : g_dec
    assign ch_addr[gi] = pend_addr_reg[gi*IN_WIDTH +: IN_WIDTH];
    multi_decoder_dec #(
      .IN_WIDTH(IN_WIDTH),
      .ACTIVE  (1)
    ) u_dec (
      .addr  (ch_addr[gi]),
      .onehot(dec_onehot[gi])
    );
  end

  // Pick this beat's channels: a pending channel is served unless a lower-index
  // pending channel has the same address
  always_comb begin
    logic hit;
    serve_next = '0;
    beat_next  = '0;
    hit        = 1'b0;
    for (int k = 0; k < CH; k++) begin
      hit = 1'b0;
      for (int j = 0; j < k; j++) begin
        if (pend_mask_reg[j] && (ch_addr[j] == ch_addr[k])) begin
          hit = 1'b1;
        end
      end
      if (pend_mask_reg[k] && !hit) begin
        serve_next[k] = 1'b1;
        beat_next     = beat_next | dec_onehot[k];
      end
    end
    remain_next = pend_mask_reg & ~serve_next;
  end

  // Handshake: take a new request only once everything pending has been issued
  // and the output slot is free or emptying this cycle
  always_comb begin
    in_ready = !rst && en && (pend_mask_reg == '0) && (!out_valid_reg || out_ready);
    accept   = in_valid && in_ready;
    load     = en && (state_reg == SERVE) && (!out_valid_reg || out_ready);
  end

  // FSM with pending register and registered output beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      pend_addr_reg  <= '0;
      pend_mask_reg  <= '0;
      out_valid_reg  <= 1'b0;
      out_onehot_reg <= '0;
      out_ch_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            pend_addr_reg <= in_addr;
            pend_mask_reg <= in_mask;
            state_reg     <= (in_mask != '0) ? SERVE : IDLE;
          end
        end
        SERVE: begin
          if (load) begin
            pend_mask_reg <= remain_next;
            state_reg     <= (remain_next == '0) ? IDLE : SERVE;
          end
        end
        default: state_reg <= IDLE;
      endcase

      if (load) begin
        out_valid_reg  <= 1'b1;
        out_onehot_reg <= beat_next;
        out_ch_reg     <= serve_next;
      end else if (en && out_valid_reg && out_ready) begin
        out_valid_reg  <= 1'b0;
      end
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_ch     = out_ch_reg;
  assign out_onehot = (ACTIVE != 0) ? out_onehot_reg : ~out_onehot_reg;

endmodule

// File: tb/tb_multi_decoder.sv
// Directed testbench for multi_decoder (IN_WIDTH=5, CH=2), one active-high and
// one active-low instance. Define MULTI_DECODER_ENABLE_PIN_EN to exercise enable.
module tb_multi_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [9:0]  a_in_addr;
  logic [1:0]  a_in_mask, a_out_ch;
  logic [31:0] a_out_onehot;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [9:0]  b_in_addr;
  logic [1:0]  b_in_mask, b_out_ch;
  logic [31:0] b_out_onehot;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_decoder #(.IN_WIDTH(5), .CH(2), .ACTIVE(1)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_addr   (a_in_addr),
    .in_mask   (a_in_mask),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
`ifdef MULTI_DECODER_ENABLE_PIN_EN
    .enable    (enable),
`endif
    .out_onehot(a_out_onehot),
    .out_ch    (a_out_ch)
  );

  multi_decoder #(.IN_WIDTH(5), .CH(2), .ACTIVE(0)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_addr   (b_in_addr),
    .in_mask   (b_in_mask),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
`ifdef MULTI_DECODER_ENABLE_PIN_EN
    .enable    (1'b1),
`endif
    .out_onehot(b_out_onehot),
    .out_ch    (b_out_ch)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1;
    a_in_valid = 0; a_in_addr = '0; a_in_mask = '0; a_out_ready = 1;
    b_in_valid = 0; b_in_addr = '0; b_in_mask = '0; b_out_ready = 1;
    #2;
    $display("reset asserted");
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_ch", a_out_ch, 0);
    chk("rst_onehot_hi", a_out_onehot, 32'h0000_0000);
    chk("rst_onehot_lo", b_out_onehot, 32'hFFFF_FFFF);
    chk("rst_in_ready", a_in_ready, 0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", a_in_ready, 1);

    // Two distinct addresses: single beat
    $display("txn: addr {3,7} mask 11");
    a_in_addr = {5'd7, 5'd3}; a_in_mask = 2'b11; a_in_valid = 1;
    tick();
    a_in_valid = 0;
    chk("t1_lat0_valid", a_out_valid, 0);
    chk("t1_busy_ready", a_in_ready, 0);
    tick();
    chk("t1_valid", a_out_valid, 1);
    chk("t1_onehot", a_out_onehot, 32'h0000_0088);
    chk("t1_ch", a_out_ch, 2'b11);
    tick();
    chk("t1_done_valid", a_out_valid, 0);
    chk("t1_done_ready", a_in_ready, 1);

    // Collision: two beats
    $display("txn: addr {4,4} mask 11");
    a_in_addr = {5'd4, 5'd4}; a_in_mask = 2'b11; a_in_valid = 1;
    tick();
    a_in_valid = 0;
    chk("col_ready0", a_in_ready, 0);
    tick();
    chk("col_b1_valid", a_out_valid, 1);
    chk("col_b1_ch", a_out_ch, 2'b01);
    chk("col_b1_onehot", a_out_onehot, 32'h0000_0010);
    chk("col_b1_ready", a_in_ready, 0);
    tick();
    chk("col_b2_valid", a_out_valid, 1);
    chk("col_b2_ch", a_out_ch, 2'b10);
    chk("col_b2_onehot", a_out_onehot, 32'h0000_0010);
    chk("col_b2_ready", a_in_ready, 1);
    tick();
    chk("col_done_valid", a_out_valid, 0);

    // Backpressure then back-to-back acceptance
    $display("txn: addr {1,2} mask 11 with backpressure");
    a_in_addr = {5'd2, 5'd1}; a_in_mask = 2'b11; a_in_valid = 1; a_out_ready = 0;
    tick();
    a_in_valid = 0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", a_out_valid, 1);
      chk("bp_onehot", a_out_onehot, 32'h0000_0006);
      chk("bp_ch", a_out_ch, 2'b11);
      chk("bp_ready", a_in_ready, 0);
      tick();
    end
    $display("txn: release + back-to-back addr {31,0} mask 01");
    a_out_ready = 1; a_in_addr = {5'd31, 5'd0}; a_in_mask = 2'b01; a_in_valid = 1;
    #1;
    chk("b2b_ready", a_in_ready, 1);
    tick();
    a_in_valid = 0;
    chk("b2b_consumed", a_out_valid, 0);
    tick();
    chk("b2b_valid", a_out_valid, 1);
    chk("b2b_onehot", a_out_onehot, 32'h0000_0001);
    chk("b2b_ch", a_out_ch, 2'b01);
    tick();
    chk("b2b_done", a_out_valid, 0);

    // Empty request is accepted and dropped
    $display("txn: empty mask");
    a_in_addr = {5'd6, 5'd6}; a_in_mask = 2'b00; a_in_valid = 1;
    #1;
    chk("empty_ready", a_in_ready, 1);
    tick();
    a_in_valid = 0;
    chk("empty_valid0", a_out_valid, 0);
    chk("empty_idle_ready", a_in_ready, 1);
    tick();
    chk("empty_valid1", a_out_valid, 0);

    // Reset during a two-beat collision
    $display("txn: addr {9,9} mask 11, reset mid-way");
    a_in_addr = {5'd9, 5'd9}; a_in_mask = 2'b11; a_in_valid = 1; a_out_ready = 0;
    tick();
    a_in_valid = 0;
    tick();
    chk("mid_b1_ch", a_out_ch, 2'b01);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", a_out_valid, 0);
    chk("mid_rst_ready", a_in_ready, 0);
    chk("mid_rst_onehot", a_out_onehot, 32'h0);
    tick();
    rst = 1'b0; a_out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_no_beat", a_out_valid, 0);
    end

`ifdef MULTI_DECODER_ENABLE_PIN_EN
    $display("txn: addr {5,5} mask 11 with enable gap");
    a_in_addr = {5'd5, 5'd5}; a_in_mask = 2'b11; a_in_valid = 1;
    tick();
    a_in_valid = 0;
    tick();
    chk("en_b1_ch", a_out_ch, 2'b01);
    enable = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("en_hold_valid", a_out_valid, 1);
      chk("en_hold_ch", a_out_ch, 2'b01);
      chk("en_hold_onehot", a_out_onehot, 32'h0000_0020);
      chk("en_hold_ready", a_in_ready, 0);
    end
    enable = 1;
    tick();
    chk("en_b2_valid", a_out_valid, 1);
    chk("en_b2_ch", a_out_ch, 2'b10);
    chk("en_b2_onehot", a_out_onehot, 32'h0000_0020);
    tick();
    chk("en_done", a_out_valid, 0);
`endif

    // Active-low instance
    $display("txn: active-low addr {0} mask 01");
    b_in_addr = 10'd0; b_in_mask = 2'b01; b_in_valid = 1;
    tick();
    b_in_valid = 0;
    tick();
    chk("lo_valid", b_out_valid, 1);
    chk("lo_onehot", b_out_onehot, 32'hFFFF_FFFE);
    chk("lo_ch", b_out_ch, 2'b01);
    tick();
    chk("lo_done", b_out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
